// File: rtl/pll_reset_sequencer.sv
// Reset and clock-enable sequencer for logic clocked from a PLL output.
// Holds reset until lock is stable, then releases it and runs enable dividers.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024,
    parameter int NUM_CE      = 2,
    parameter int DIV_W       = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    pll_lock,
    input  logic [NUM_CE*DIV_W-1:0] ce_div,
    output logic                    sys_reset,
    output logic                    sys_resetn,
    output logic                    ready,
    output logic [NUM_CE-1:0]       ce,
    output logic [7:0]              lock_loss_count
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [SYNC_STAGES-1:0]    sync_q, sync_d;
    logic [HCW-1:0]            hold_q, hold_d;
    logic [7:0]                loss_q, loss_d;
    logic [NUM_CE*DIV_W-1:0]   div_q, div_d;
    logic                      sys_reset_q, sys_reset_d;
    logic                      ready_q, ready_d;
    logic                      lock_s;
    logic                      run_now;
    logic                      run_next;

    assign lock_s   = sync_q[SYNC_STAGES-1];
    assign run_now  = (state_q == RUN);
    assign run_next = (state_d == RUN);

    // Lock synchroniser: the only place pll_lock is sampled.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock};
    end

    // Sequencer next state, hold counter and saturating loss counter.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        loss_d  = loss_q;
        unique case (state_q)
            WAIT_LOCK: begin
                hold_d = '0;
                if (lock_s) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            RUN: begin
                hold_d = '0;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                hold_d  = '0;
            end
        endcase
    end

    // Ratio latch tracks ce_div outside RUN and freezes while running;
    // reset outputs are decoded from the next state.
    always_comb begin
        div_d       = run_now ? div_q : ce_div;
        sys_reset_d = !run_next;
        ready_d     = run_next;
    end

    // Sequencer state and registered reset outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= WAIT_LOCK;
            sync_q      <= '0;
            hold_q      <= '0;
            loss_q      <= '0;
            div_q       <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            hold_q      <= hold_d;
            loss_q      <= loss_d;
            div_q       <= div_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

    for (genvar k = 0; k < NUM_CE; k++) begin : g_ch
        logic [DIV_W-1:0] ratio;
        logic [DIV_W-1:0] last;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic             ce_q, ce_d;

        assign ratio = div_d[k*DIV_W +: DIV_W];
        assign last  = ratio - DIV_W'(1);

        // Divider: counts only while staying in RUN; strobe on the wrap value.
        always_comb begin
            cnt_d = '0;
            ce_d  = 1'b0;
            if (run_now && run_next && (ratio > DIV_W'(1))) begin
                cnt_d = (cnt_q == last) ? '0 : cnt_q + DIV_W'(1);
            end
            if (run_next) begin
                ce_d = (ratio > DIV_W'(1)) ? (cnt_d == last) : 1'b1;
            end
        end

        // Per-channel counter and registered strobe.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                cnt_q <= '0;
                ce_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ce_q  <= ce_d;
            end
        end

        assign ce[k] = ce_q;
    end

    assign sys_reset       = sys_reset_q;
    assign sys_resetn      = ~sys_reset_q;
    assign ready           = ready_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer.
// Expected output vectors are queued by cycle; a monitor checks them.
module tb_pll_reset_sequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pll_lock;
    logic [7:0] ce_div;
    logic       sys_reset;
    logic       sys_resetn;
    logic       ready;
    logic [1:0] ce;
    logic [7:0] lock_loss_count;

    typedef struct {
        int         cyc;
        string      tag;
        logic       rst;
        logic [1:0] ce;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   e0, e1, e2, e3, e4, c, e;
    int   exp_cnt;

    pll_reset_sequencer #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(8),
        .NUM_CE(2),
        .DIV_W(4)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .pll_lock(pll_lock),
        .ce_div(ce_div),
        .sys_reset(sys_reset),
        .sys_resetn(sys_resetn),
        .ready(ready),
        .ce(ce),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic ce_exp(int d, int k);
        if (d <= 1) return 1'b1;
        return (k >= d - 1) && (((k - (d - 1)) % d) == 0);
    endfunction

    task automatic push(int cc, string tag, logic rst, logic [1:0] cev,
                        logic [7:0] cnt);
        exp_t x;
        x.cyc = cc;
        x.tag = tag;
        x.rst = rst;
        x.ce  = cev;
        x.cnt = cnt;
        sb.push_back(x);
    endtask

    task automatic push_run(int cc, string tag, int k, int d0, int d1,
                            logic [7:0] cnt);
        push(cc, tag, 1'b0, {ce_exp(d1, k), ce_exp(d0, k)}, cnt);
    endtask

    task automatic wait_cyc(int target);
        while (cyc < target) @(negedge clock);
    endtask

    // Monitor: compares every queued vector due in the current cycle.
    always @(negedge clock) begin : monitor
        exp_t x;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            x = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s cyc=%0d: vector not checked in time (now %0d)",
                     x.tag, x.cyc, cyc);
        end
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            x = sb.pop_front();
            vectors++;
            if (sys_reset !== x.rst || sys_resetn !== ~x.rst ||
                ready !== ~x.rst || ce !== x.ce ||
                lock_loss_count !== x.cnt) begin
                miscompares++;
                $display({"FAIL %s cyc=%0d: got rst=%b rstn=%b rdy=%b ce=%b",
                          " cnt=%0d, want rst=%b rstn=%b rdy=%b ce=%b cnt=%0d"},
                         x.tag, cyc, sys_reset, sys_resetn, ready, ce,
                         lock_loss_count, x.rst, ~x.rst, ~x.rst, x.ce, x.cnt);
            end
        end
    end

    initial begin
        resetn   = 1'b0;
        pll_lock = 1'b0;
        ce_div   = {4'd3, 4'd1};

        @(negedge clock);
        push(cyc + 1, "reset", 1'b1, 2'b00, 8'd0);
        push(cyc + 2, "reset", 1'b1, 2'b00, 8'd0);
        wait_cyc(cyc + 2);
        resetn = 1'b1;

        @(negedge clock);
        pll_lock = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 10; k++)
            push(e0 + k, "rel_hold", 1'b1, 2'b00, 8'd0);
        for (int k = 10; k < 32; k++)
            push_run(e0 + k, "rel_run", k - 10, 1, 3, 8'd0);
        push(e0 + 32, "loss", 1'b1, 2'b00, 8'd1);
        push(e0 + 33, "loss", 1'b1, 2'b00, 8'd1);
        wait_cyc(e0 + 29);
        pll_lock = 1'b0;

        wait_cyc(e0 + 33);
        pll_lock = 1'b1;
        e1 = cyc + 1;
        for (int k = 0; k < 10; k++)
            push(e1 + k, "relock_hold", 1'b1, 2'b00, 8'd1);
        for (int k = 10; k < 27; k++)
            push_run(e1 + k, "latch_old", k - 10, 1, 3, 8'd1);
        push(e1 + 27, "latch_loss", 1'b1, 2'b00, 8'd2);
        wait_cyc(e1 + 12);
        ce_div = {4'd2, 4'd4};
        wait_cyc(e1 + 24);
        pll_lock = 1'b0;

        wait_cyc(e1 + 28);
        pll_lock = 1'b1;
        e2 = cyc + 1;
        for (int k = 0; k < 10; k++)
            push(e2 + k, "latch_hold", 1'b1, 2'b00, 8'd2);
        for (int k = 10; k < 28; k++)
            push_run(e2 + k, "latch_new", k - 10, 4, 2, 8'd2);
        push(e2 + 28, "loss3", 1'b1, 2'b00, 8'd3);
        wait_cyc(e2 + 25);
        pll_lock = 1'b0;

        wait_cyc(e2 + 29);
        pll_lock = 1'b1;
        e3 = cyc + 1;
        for (int k = 0; k < 19; k++)
            push(e3 + k, "restart_hold", 1'b1, 2'b00, 8'd3);
        for (int k = 19; k < 25; k++)
            push_run(e3 + k, "restart_run", k - 19, 4, 2, 8'd3);
        push(e3 + 25, "loss4", 1'b1, 2'b00, 8'd4);
        wait_cyc(e3 + 5);
        pll_lock = 1'b0;
        wait_cyc(e3 + 8);
        pll_lock = 1'b1;
        wait_cyc(e3 + 22);
        pll_lock = 1'b0;
        wait_cyc(e3 + 26);

        exp_cnt = 4;
        for (int i = 0; i < 260; i++) begin
            @(negedge clock);
            pll_lock = 1'b1;
            e = cyc + 1;
            wait_cyc(e + 10);
            pll_lock = 1'b0;
            if (exp_cnt < 255) exp_cnt++;
            push(e + 13, "sat", 1'b1, 2'b00, 8'(exp_cnt));
            wait_cyc(e + 13);
        end

        @(negedge clock);
        pll_lock = 1'b1;
        e4 = cyc + 1;
        for (int k = 0; k < 10; k++)
            push(e4 + k, "sat_hold", 1'b1, 2'b00, 8'd255);
        for (int k = 10; k < 15; k++)
            push_run(e4 + k, "sat_run", k - 10, 4, 2, 8'd255);
        wait_cyc(e4 + 14);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        push(cyc, "async", 1'b1, 2'b00, 8'd0);
        push(cyc + 1, "async_hold", 1'b1, 2'b00, 8'd0);
        @(negedge clock);
        @(negedge clock);
        ce_div = {4'd0, 4'd15};
        resetn = 1'b1;
        c = cyc;
        for (int k = 1; k < 11; k++)
            push(c + k, "r0_hold", 1'b1, 2'b00, 8'd0);
        for (int k = 11; k < 46; k++)
            push_run(c + k, "ratio0", k - 11, 15, 0, 8'd0);
        wait_cyc(c + 45);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d vectors left, want 0", sb.size());
            miscompares += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
